nco_voice: RTL and testbench

- Single-voice oscillator stage directly downstream of the keyboard note mux.
- Consumes the 32-bit phase increment (idxjmp) and advances a phase accumulator once per audio sample tick (48 kHz strobe).
- Shapes the phase into a square, saw or triangle sample and scales it with a linear attack/release envelope.
- Delivers one signed sample per tick to the audio output/mixer path.

---
 rtl/nco_voice.sv | 109 ++++++++++
 tb/tb_nco_voice.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_voice.sv
// Single-voice NCO: phase accumulator, square/saw/triangle shaper and linear
// attack/release envelope, advancing once per sample_tick.
module nco_voice #(
   parameter logic [15:0] ATTACK_STEP  = 16'h0100,
   parameter logic [15:0] RELEASE_STEP = 16'h0080
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        sample_tick,
   input  logic [31:0] idxjmp,
   input  logic [1:0]  wave_sel,
   output logic [15:0] sample_out,
   output logic        sample_valid,
   output logic        active,
   output logic [1:0]  env_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t              state;
   logic [31:0]         phase;
   logic [15:0]         env;
   logic                key;
   logic [16:0]         env_sum;
   logic signed [15:0]  raw;
   logic signed [32:0]  prod;
   logic                unused_ok;

   assign key       = |idxjmp;
   assign env_sum   = {1'b0, env} + {1'b0, ATTACK_STEP};
   assign prod      = raw * $signed({1'b0, env});
   assign unused_ok = ^{prod[32], prod[15:0]};
   assign env_state = state;

   // Triangle uses 16-bit wrapping arithmetic; the true 17-bit result always fits.
   always_comb begin
      raw = '0;
      unique case (wave_sel)
         2'd0:    raw = phase[31] ? 16'sh8000 : 16'sh7FFF;
         2'd1:    raw = phase[31:16] ^ 16'h8000;
         2'd2:    raw = phase[31] ? (16'h7FFF - phase[30:15]) : (phase[30:15] - 16'h8000);
         default: raw = '0;
      endcase
   end

   // sample_valid is a one-cycle strobe with no backpressure: the consumer must
   // capture sample_out in the cycle sample_valid is high; it then holds until
   // the next strobe.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         phase        <= '0;
         env          <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         active       <= 1'b0;
      end else begin
         sample_valid <= sample_tick;
         if (sample_tick) begin
            sample_out <= prod[31:16];
            unique case (state)
               IDLE: begin
                  if (key) begin
                     state  <= ATTACK;
                     active <= 1'b1;
                     phase  <= idxjmp;
                  end
               end
               ATTACK: begin
                  if (!key) begin
                     state <= RELEASE;
                  end else begin
                     phase <= phase + idxjmp;
                     if (env_sum[16] || env_sum[15:0] == 16'hFFFF) begin
                        env   <= 16'hFFFF;
                        state <= SUSTAIN;
                     end else begin
                        env <= env_sum[15:0];
                     end
                  end
               end
               SUSTAIN: begin
                  if (!key) state <= RELEASE;
                  else      phase <= phase + idxjmp;
               end
               RELEASE: begin
                  if (key) begin
                     state <= ATTACK;
                     phase <= phase + idxjmp;
                  end else if (env <= RELEASE_STEP) begin
                     env    <= '0;
                     state  <= IDLE;
                     active <= 1'b0;
                  end else begin
                     env <= env - RELEASE_STEP;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nco_voice.sv
// Bench for nco_voice: directed scenarios plus randomized key/wave traffic,
// compared against an integer-arithmetic voice model.
`timescale 1ns/1ps
module tb_nco_voice;

   localparam int AS = 4096;
   localparam int RS = 32768;
   localparam int S_IDLE = 0, S_ATK = 1, S_SUS = 2, S_REL = 3;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        sample_tick = 1'b0;
   logic [31:0] idxjmp = '0;
   logic [1:0]  wave_sel = '0;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        active;
   logic [1:0]  env_state;

   int checks = 0;
   int errors = 0;
   int tick_no = 0;

   logic [15:0] exp_q[$];
   bit   [31:0] m_phase;
   int          m_env;
   int          m_state;
   bit          m_active;

   nco_voice #(.ATTACK_STEP(16'h1000), .RELEASE_STEP(16'h8000)) dut (
      .Clk(Clk), .Reset(Reset), .sample_tick(sample_tick), .idxjmp(idxjmp),
      .wave_sel(wave_sel), .sample_out(sample_out), .sample_valid(sample_valid),
      .active(active), .env_state(env_state)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int model_raw(bit [31:0] p, bit [1:0] w);
      int x;
      x = int'(p[30:15]);
      case (w)
         2'd0:    return p[31] ? -32768 : 32767;
         2'd1:    return int'(p >> 16) - 32768;
         2'd2:    return p[31] ? (32767 - x) : (x - 32768);
         default: return 0;
      endcase
   endfunction

   function automatic int model_scale(int r, int e);
      longint p;
      p = longint'(r) * longint'(e);
      return int'(p >>> 16);
   endfunction

   task automatic model_reset();
      m_phase = '0; m_env = 0; m_state = S_IDLE; m_active = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step(input bit [31:0] idx);
      bit key;
      key = (idx != 0);
      case (m_state)
         S_IDLE: if (key) begin m_state = S_ATK; m_phase = idx; end
         S_ATK: begin
            if (!key) m_state = S_REL;
            else begin
               m_phase += idx;
               m_env = (m_env + AS > 65535) ? 65535 : m_env + AS;
               if (m_env == 65535) m_state = S_SUS;
            end
         end
         S_SUS: if (!key) m_state = S_REL; else m_phase += idx;
         default: begin
            if (key) begin m_state = S_ATK; m_phase += idx; end
            else begin
               m_env = (m_env > RS) ? m_env - RS : 0;
               if (m_env == 0) m_state = S_IDLE;
            end
         end
      endcase
      m_active = (m_state != S_IDLE);
   endtask

   // Driver plus scoreboard: one tick, then `gap` idle cycles with junk inputs.
   task automatic do_tick(input logic [31:0] idx, input logic [1:0] w, input int gap);
      logic [15:0] exp_out;
      logic [1:0]  exp_st;
      int r;
      r = model_scale(model_raw(m_phase, w), m_env);
      exp_q.push_back(r[15:0]);
      model_step(idx);
      exp_st = m_state[1:0];
      idxjmp = idx; wave_sel = w; sample_tick = 1'b1;
      @(posedge Clk); #1;
      sample_tick = 1'b0;
      tick_no++;
      exp_out = exp_q.pop_front();
      checks++;
      if (sample_out !== exp_out) begin
         errors++;
         $display("FAIL sample_out tick %0d: got %0d want %0d", tick_no, $signed(sample_out), $signed(exp_out));
      end
      checks++;
      if (sample_valid !== 1'b1) begin
         errors++; $display("FAIL sample_valid tick %0d: got %b want 1", tick_no, sample_valid);
      end
      checks++;
      if (active !== m_active) begin
         errors++; $display("FAIL active tick %0d: got %b want %b", tick_no, active, m_active);
      end
      checks++;
      if (env_state !== exp_st) begin
         errors++; $display("FAIL env_state tick %0d: got %0d want %0d", tick_no, env_state, exp_st);
      end
      for (int i = 0; i < gap; i++) begin
         idxjmp = $urandom; wave_sel = 2'($urandom_range(0, 3));
         @(posedge Clk); #1;
         checks++;
         if (sample_valid !== 1'b0 || sample_out !== exp_out) begin
            errors++;
            $display("FAIL hold tick %0d: valid %b out %0d want valid 0 out %0d", tick_no, sample_valid, $signed(sample_out), $signed(exp_out));
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; sample_tick = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      checks++;
      if (sample_out !== 16'h0 || sample_valid !== 1'b0 || active !== 1'b0 || env_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_outputs: out %h valid %b active %b state %0d want 0 0 0 0", sample_out, sample_valid, active, env_state);
      end
      checks++;
      if (dut.phase !== 32'h0 || dut.env !== 16'h0) begin
         errors++; $display("FAIL reset_regs: phase %h env %h want 0 0", dut.phase, dut.env);
      end
      Reset = 1'b0;
      model_reset();
   endtask

   task automatic test_idle();
      for (int n = 0; n < 5; n++) do_tick(32'h0, 2'($urandom_range(0, 3)), 1);
      checks++;
      if (sample_out !== 16'h0 || active !== 1'b0) begin
         errors++; $display("FAIL idle: out %0d active %b want 0 0", $signed(sample_out), active);
      end
   endtask

   task automatic test_attack();
      logic [31:0] a;
      longint t;
      a = 32'd19685267;
      for (int n = 1; n <= 17; n++) begin
         do_tick(a, 2'd0, 0);
         if (n == 1) begin
            checks++;
            if (active !== 1'b1) begin
               errors++; $display("FAIL attack_active: got %b want 1", active);
            end
         end
         if (n == 16) begin
            checks++;
            if (env_state !== 2'd1 || dut.env !== 16'hF000) begin
               errors++; $display("FAIL attack_tick16: state %0d env %h want 1 f000", env_state, dut.env);
            end
         end
      end
      t = 64'd17 * longint'(a);
      checks++;
      if (env_state !== 2'd2 || dut.env !== 16'hFFFF) begin
         errors++; $display("FAIL attack_sustain: state %0d env %h want 2 ffff", env_state, dut.env);
      end
      checks++;
      if (dut.phase !== t[31:0]) begin
         errors++; $display("FAIL attack_phase: got %h want %h", dut.phase, t[31:0]);
      end
   endtask

   task automatic test_saw();
      int exp_tbl[5];
      int e;
      exp_tbl = '{-16384, 0, 16383, -32768, -16384};
      for (int n = 0; n < 17; n++) do_tick(32'h4000_0000, 2'd1, 0);
      for (int n = 0; n < 5; n++) begin
         do_tick(32'h4000_0000, 2'd1, 1);
         e = exp_tbl[n];
         checks++;
         if (sample_out !== e[15:0]) begin
            errors++; $display("FAIL saw_seq %0d: got %0d want %0d", n, $signed(sample_out), e);
         end
      end
   endtask

   task automatic test_release();
      logic [31:0] ph;
      ph = dut.phase;
      do_tick(32'h0, 2'd0, 0);
      do_tick(32'h0, 2'd0, 0);
      checks++;
      if (dut.env !== 16'h7FFF || env_state !== 2'd3) begin
         errors++; $display("FAIL release_7fff: env %h state %0d want 7fff 3", dut.env, env_state);
      end
      do_tick(32'h0, 2'd2, 0);
      checks++;
      if (dut.env !== 16'h0 || env_state !== 2'd0 || active !== 1'b0) begin
         errors++; $display("FAIL release_idle: env %h state %0d active %b want 0 0 0", dut.env, env_state, active);
      end
      for (int n = 0; n < 3; n++) begin
         do_tick(32'h0, 2'($urandom_range(0, 2)), 0);
         checks++;
         if (sample_out !== 16'h0) begin
            errors++; $display("FAIL release_silent: got %0d want 0", $signed(sample_out));
         end
      end
      checks++;
      if (dut.phase !== ph) begin
         errors++; $display("FAIL release_phase: got %h want %h", dut.phase, ph);
      end
   endtask

   task automatic test_retrigger();
      logic [31:0] a, b, ph;
      a = 32'd19685267;
      for (int n = 0; n < 17; n++) do_tick(a, 2'd2, 0);
      do_tick(32'h0, 2'd2, 0);
      do_tick(32'h0, 2'd2, 0);
      ph = dut.phase;
      do_tick(a, 2'd2, 0);
      checks++;
      if (env_state !== 2'd1 || dut.env !== 16'h7FFF || dut.phase !== ph + a) begin
         errors++;
         $display("FAIL retrigger: state %0d env %h phase %h want 1 7fff %h", env_state, dut.env, dut.phase, ph + a);
      end
      for (int n = 0; n < 9; n++) do_tick(a, 2'd2, 0);
      checks++;
      if (env_state !== 2'd2 || dut.env !== 16'hFFFF) begin
         errors++; $display("FAIL retrigger_sustain: state %0d env %h want 2 ffff", env_state, dut.env);
      end
      b = $urandom | 32'h1;
      ph = dut.phase;
      do_tick(b, 2'd1, 0);
      checks++;
      if (env_state !== 2'd2 || dut.phase !== ph + b) begin
         errors++; $display("FAIL legato: state %0d phase %h want 2 %h", env_state, dut.phase, ph + b);
      end
      do_tick(b, 2'd3, 0);
      checks++;
      if (sample_out !== 16'h0) begin
         errors++; $display("FAIL mute: got %0d want 0", $signed(sample_out));
      end
   endtask

   task automatic test_reset_tick();
      for (int n = 0; n < 17; n++) do_tick(32'h1234_5678, 2'd0, 0);
      Reset = 1'b1; sample_tick = 1'b1; idxjmp = 32'h1234_5678;
      @(posedge Clk); #1;
      Reset = 1'b0; sample_tick = 1'b0;
      model_reset();
      checks++;
      if (sample_out !== 16'h0 || sample_valid !== 1'b0 || active !== 1'b0 || env_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_tick: out %h valid %b active %b state %0d want 0 0 0 0", sample_out, sample_valid, active, env_state);
      end
      checks++;
      if (dut.phase !== 32'h0 || dut.env !== 16'h0) begin
         errors++; $display("FAIL reset_tick_regs: phase %h env %h want 0 0", dut.phase, dut.env);
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 40; s++) begin
         int len;
         logic [31:0] idx;
         len = $urandom_range(1, 25);
         idx = ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom | 32'h1);
         for (int k = 0; k < len; k++) begin
            if (idx != 0 && $urandom_range(0, 7) == 0) idx = $urandom | 32'h1;
            do_tick(idx, 2'($urandom_range(0, 3)), $urandom_range(0, 2));
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_attack();
      test_reset();
      test_saw();
      test_release();
      test_reset();
      test_retrigger();
      test_reset_tick();
      test_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
